// File: rtl/mac_vector_engine_if.sv
// ---------------------------------------------------------------------------
// mac_vector_engine_if
//   CPU look-ahead bus bundle for the MAC vector engine register region.
//
//   Signals:
//     bus_sel    master->slave  access targets this block's region
//     bus_addr   master->slave  byte offset within the region (6 bits)
//     bus_write  master->slave  write strobe
//     bus_read   master->slave  read strobe
//     bus_wdata  master->slave  write data
//     bus_rdata  slave->master  registered read data
//     bus_ready  slave->master  high when the engine can accept an access
//
//   Handshake: a request (bus_sel with bus_read or bus_write) is taken in
//   the cycle where bus_ready is also high. While bus_ready is low the
//   master holds the request unchanged. Each taken request is performed
//   exactly once. Read data appears on bus_rdata the cycle after the read
//   is taken.
// ---------------------------------------------------------------------------
interface mac_vector_engine_if;
    logic        bus_sel;
    logic [5:0]  bus_addr;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_sel, bus_addr, bus_write, bus_read, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_sel, bus_addr, bus_write, bus_read, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/mac_vector_engine.sv
// ---------------------------------------------------------------------------
// mac_vector_engine
//   Memory-mapped multiply-accumulate engine. The CPU programs a data
//   address, strides, a tap count and a start coefficient index, then
//   writes START. The engine issues one RAM/ROM operand pair per cycle,
//   multiplies them at full precision and adds (or subtracts) the product
//   into the selected accumulator, optionally saturating.
//
//   Ports:
//     clk, resetn   clock, synchronous active-low reset
//     bus           register bus (slave modport of mac_vector_engine_if)
//     ram_addr      byte address of the data word being fetched
//     ram_rdata     data word, valid one cycle after ram_addr
//     coef_index    coefficient ROM index
//     coef_data     coefficient, valid one cycle after coef_index
//     busy          high while a run is in progress
//
//   Timeline of a run with T taps (cycle 0 = START write):
//     cycles 1..T     FETCH, issue k = cycle-1
//     cycles T+1,T+2  DRAIN, last operands land then accumulate
//     cycle  T+3      IDLE, result visible
// ---------------------------------------------------------------------------
module mac_vector_engine #(
    parameter int DATA_W  = 32,
    parameter int COEF_W  = 18,
    parameter int ACC_W   = 32,
    parameter int IDX_W   = 9,
    parameter int NUM_ACC = 2,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    mac_vector_engine_if.slave     bus,
    output logic [31:0]            ram_addr,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [IDX_W-1:0]       coef_index,
    input  logic [COEF_W-1:0]      coef_data,
    output logic                   busy
);
    localparam int SEL_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Configuration registers
    logic [31:0]       data_addr_q;
    logic [CNT_W-1:0]  taps_q;
    logic [7:0]        coef_stride_q;
    logic [1:0]        mode_q;
    logic [31:0]       data_stride_q;
    logic [SEL_W-1:0]  acc_sel_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  acc_q [NUM_ACC];

    // Run state
    logic [31:0]       ptr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              drain_q;

    // Operand pipeline
    logic              v1_q;       // operands for an issue are on ram_rdata/coef_data
    logic              s1_v_q;     // stage-1 registers hold a valid pair
    logic [DATA_W-1:0] s1_data_q;
    logic [COEF_W-1:0] s1_coef_q;

    logic [31:0]       rdata_q, rdata_d;

    // Bus decode: requests are only taken while IDLE, so a stalled request
    // has no side effect until it is finally accepted.
    logic take, wr_en, rd_en, go;
    assign take  = bus.bus_sel && (state_q == IDLE);
    assign wr_en = take && bus.bus_write;
    assign rd_en = take && bus.bus_read;
    assign go    = wr_en && (bus.bus_addr == 6'h04) && (taps_q != '0);

    assign bus.bus_ready = (state_q == IDLE);
    assign bus.bus_rdata = rdata_q;
    assign busy          = (state_q != IDLE);
    assign ram_addr      = ptr_q;
    assign coef_index    = idx_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = FETCH;
            FETCH:   if (cnt_q == CNT_W'(1)) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- MAC arithmetic ----------------
    logic [ACC_W-1:0]        acc_cur, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  acc_ext, prod_ext, sum;
    logic [SUM_W-ACC_W:0]     sum_hi;
    logic                     sat_hit;

    always_comb begin
        acc_cur  = acc_q[acc_sel_q];
        // Both operands sign-extended to the product width so the truncated
        // product is the exact signed result.
        prod     = $signed({{COEF_W{s1_data_q[DATA_W-1]}}, s1_data_q})
                 * $signed({{DATA_W{s1_coef_q[COEF_W-1]}}, s1_coef_q});
        acc_ext  = $signed({{(SUM_W-ACC_W){acc_cur[ACC_W-1]}}, acc_cur});
        prod_ext = $signed({{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod});
        sum      = mode_q[1] ? (acc_ext - prod_ext) : (acc_ext + prod_ext);
        // The sum fits the accumulator when all bits above the accumulator
        // sign bit agree with it.
        sum_hi   = sum[SUM_W-1:ACC_W-1];
        sat_hit  = 1'b0;
        acc_d    = sum[ACC_W-1:0];
        if (mode_q[0] && !((&sum_hi) || !(|sum_hi))) begin
            sat_hit = 1'b1;
            acc_d   = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        rdata_d = 32'h0;
        unique case (bus.bus_addr)
            6'h00: rdata_d = data_addr_q;
            6'h0C: begin
                rdata_d[CNT_W-1:0] = taps_q;
                rdata_d[15:8]      = coef_stride_q;
                rdata_d[17:16]     = mode_q;
            end
            6'h10: rdata_d = data_stride_q;
            6'h14: rdata_d[SEL_W-1:0] = acc_sel_q;
            6'h18: rdata_d[1:0] = {ovf_q, busy};
            default: begin
                for (int n = 0; n < NUM_ACC; n++) begin
                    if (bus.bus_addr == 6'(32 + 4 * n)) rdata_d = 32'(acc_q[n]);
                end
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_addr_q   <= 32'h0;
            taps_q        <= CNT_W'(8);
            coef_stride_q <= 8'd64;
            mode_q        <= 2'b00;
            data_stride_q <= 32'd512;
            acc_sel_q     <= '0;
            ovf_q         <= 1'b0;
            for (int n = 0; n < NUM_ACC; n++) acc_q[n] <= '0;
            ptr_q         <= 32'h0;
            idx_q         <= '0;
            cnt_q         <= '0;
            drain_q       <= 1'b0;
            v1_q          <= 1'b0;
            s1_v_q        <= 1'b0;
            s1_data_q     <= '0;
            s1_coef_q     <= '0;
            rdata_q       <= 32'h0;
        end else begin
            if (wr_en) begin
                unique case (bus.bus_addr)
                    6'h00: data_addr_q <= bus.bus_wdata;
                    6'h08: acc_q[acc_sel_q] <= bus.bus_wdata[ACC_W-1:0];
                    6'h0C: begin
                        taps_q        <= bus.bus_wdata[CNT_W-1:0];
                        coef_stride_q <= bus.bus_wdata[15:8];
                        mode_q        <= bus.bus_wdata[17:16];
                    end
                    6'h10: data_stride_q <= bus.bus_wdata;
                    6'h14: acc_sel_q <= bus.bus_wdata[SEL_W-1:0];
                    6'h18: if (bus.bus_wdata[1]) ovf_q <= 1'b0;
                    default: ;
                endcase
            end

            if (go) begin
                ptr_q     <= data_addr_q;
                idx_q     <= bus.bus_wdata[IDX_W-1:0];
                acc_sel_q <= bus.bus_wdata[IDX_W +: SEL_W];
                cnt_q     <= taps_q;
            end else if (state_q == FETCH) begin
                ptr_q <= ptr_q + data_stride_q;
                idx_q <= idx_q + IDX_W'(coef_stride_q);
                cnt_q <= cnt_q - CNT_W'(1);
            end

            drain_q   <= (state_q == DRAIN) ? ~drain_q : 1'b0;

            v1_q      <= (state_q == FETCH);
            s1_v_q    <= v1_q;
            s1_data_q <= ram_rdata;
            s1_coef_q <= coef_data;

            if (s1_v_q) begin
                acc_q[acc_sel_q] <= acc_d;
                if (sat_hit) ovf_q <= 1'b1;
            end

            if (rd_en) rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mac_vector_engine.sv
module tb_mac_vector_engine;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata;
    logic [8:0]  coef_index;
    logic [17:0] coef_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mac_vector_engine_if bif ();

    mac_vector_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bif),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .coef_index (coef_index),
        .coef_data  (coef_data),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [31:0] ram_mem [logic [31:0]];
    logic [17:0] rom [512];

    always @(posedge clk) begin
        ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'h0;
        coef_data <= rom[coef_index];
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- bus driver ----------------
    task automatic bus_op(input logic is_wr, input logic [5:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int stall);
        stall = 0;
        @(negedge clk);
        bif.bus_sel   = 1'b1;
        bif.bus_write = is_wr;
        bif.bus_read  = !is_wr;
        bif.bus_addr  = a;
        bif.bus_wdata = d;
        while (!bif.bus_ready && stall < 300) begin
            stall++;
            @(negedge clk);
        end
        if (!bif.bus_ready) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: addr 0x%02h still stalled after %0d cycles", a, stall);
        end
        @(posedge clk);
        #1;
        bif.bus_sel   = 1'b0;
        bif.bus_write = 1'b0;
        bif.bus_read  = 1'b0;
        rd = bif.bus_rdata;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] r;
        int s;
        bus_op(1'b1, a, d, r, s);
    endtask

    task automatic rd_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int s;
        bus_op(1'b0, a, 32'h0, r, s);
        check(name, r, exp);
    endtask

    // Counts busy cycles following a START write (called right after it).
    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- register vector table ----------------
    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [5:0] a, input logic [31:0] d,
                                input logic [31:0] e, input string nm);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.exp = e; v.name = nm;
        return v;
    endfunction

    vec_t tbl [$];

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stall;
        logic [31:0] r;

        bif.bus_sel = 1'b0; bif.bus_write = 1'b0; bif.bus_read = 1'b0;
        bif.bus_addr = 6'h0; bif.bus_wdata = 32'h0;
        for (int i = 0; i < 512; i++) rom[i] = 18'h0;
        for (int k = 0; k < 8; k++) begin
            ram_mem[32'h1000 + 32'(512 * k)] = 32'(k + 1);
            rom[64 * k] = 18'd2;
        end
        ram_mem[32'h2000] = 32'h7FFF_FFFF;
        rom[500] = 18'd3;
        rom[52]  = 18'd5;

        tbl.push_back(mk(0, 6'h0C, 0,            32'h0000_4008, "config_reset"));
        tbl.push_back(mk(0, 6'h10, 0,            32'd512,       "stride_reset"));
        tbl.push_back(mk(0, 6'h20, 0,            32'h0,         "acc0_reset"));
        tbl.push_back(mk(0, 6'h24, 0,            32'h0,         "acc1_reset"));
        tbl.push_back(mk(0, 6'h18, 0,            32'h0,         "status_reset"));
        tbl.push_back(mk(1, 6'h00, 32'h12345678, 0,             "w_data_addr"));
        tbl.push_back(mk(0, 6'h00, 0,            32'h1234_5678, "data_addr_rb"));
        tbl.push_back(mk(1, 6'h0C, 32'hFFFFFFFF, 0,             "w_config"));
        tbl.push_back(mk(0, 6'h0C, 0,            32'h0003_FFFF, "config_rb"));
        tbl.push_back(mk(1, 6'h14, 32'h3,        0,             "w_acc_sel"));
        tbl.push_back(mk(0, 6'h14, 0,            32'h1,         "acc_sel_rb"));
        tbl.push_back(mk(1, 6'h1C, 32'hFFFFFFFF, 0,             "w_undef"));
        tbl.push_back(mk(0, 6'h1C, 0,            32'h0,         "undef_1c"));
        tbl.push_back(mk(0, 6'h3C, 0,            32'h0,         "undef_3c"));
        tbl.push_back(mk(1, 6'h08, 32'hDEADBEEF, 0,             "w_acc_load"));
        tbl.push_back(mk(0, 6'h24, 0,            32'hDEAD_BEEF, "acc1_loaded"));
        tbl.push_back(mk(0, 6'h20, 0,            32'h0,         "acc0_untouched"));

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_ready",  32'(bif.bus_ready), 32'h1);
        check("rst_ramadr", ram_addr, 32'h0);
        check("rst_coefix", 32'(coef_index), 32'h0);
        check("rst_rdata",  bif.bus_rdata, 32'h0);

        // ---------------- register table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
            else              rd_check(tbl[i].name, tbl[i].addr, tbl[i].exp);
        end

        // ---------------- basic accumulate into ACC[0] ----------------
        wr(6'h14, 32'h0);
        wr(6'h08, 32'd100);
        wr(6'h00, 32'h1000);
        wr(6'h0C, 32'h4008);
        wr(6'h04, 32'h0);
        wait_idle(n);
        check("add_busy_cycles", 32'(n), 32'd10);
        rd_check("add_acc0", 6'h20, 32'd172);

        // ---------------- subtract into ACC[1] ----------------
        wr(6'h14, 32'h1);
        wr(6'h08, 32'h0);
        wr(6'h0C, 32'h0002_4008);
        wr(6'h04, 32'h200);
        wait_idle(n);
        check("sub_busy_cycles", 32'(n), 32'd10);
        rd_check("sub_acc1", 6'h24, 32'hFFFF_FFB8);
        rd_check("sub_acc0_kept", 6'h20, 32'd172);

        // ---------------- coefficient index wrap ----------------
        wr(6'h0C, 32'h4002);
        wr(6'h04, 32'd500);
        @(negedge clk);
        check("wrap_idx0", 32'(coef_index), 32'd500);
        check("wrap_adr0", ram_addr, 32'h1000);
        @(negedge clk);
        check("wrap_idx1", 32'(coef_index), 32'd52);
        check("wrap_adr1", ram_addr, 32'h1200);
        wait_idle(n);
        rd_check("wrap_acc0", 6'h20, 32'd185);   // 172 + 1*3 + 2*5

        // ---------------- saturation ----------------
        rom[0] = 18'h1FFFF;
        wr(6'h14, 32'h0);
        wr(6'h08, 32'h7FFF_FFF0);
        wr(6'h00, 32'h2000);
        wr(6'h0C, 32'h0001_4001);
        wr(6'h04, 32'h0);
        wait_idle(n);
        check("sat_busy_cycles", 32'(n), 32'd3);
        rd_check("sat_acc0", 6'h20, 32'h7FFF_FFFF);
        rd_check("sat_status", 6'h18, 32'h2);
        wr(6'h18, 32'h2);
        rd_check("ovf_cleared", 6'h18, 32'h0);

        // ---------------- same operands, wrapping ----------------
        wr(6'h08, 32'h7FFF_FFF0);
        wr(6'h0C, 32'h0000_4001);
        wr(6'h04, 32'h0);
        wait_idle(n);
        rd_check("wrap_mode_acc0", 6'h20, 32'hFFFD_FFF1);
        rd_check("wrap_mode_status", 6'h18, 32'h0);

        // ---------------- read stalled behind a run ----------------
        rom[0] = 18'd2;
        wr(6'h00, 32'h1000);
        wr(6'h0C, 32'h4008);
        wr(6'h08, 32'd100);
        wr(6'h04, 32'h0);
        bus_op(1'b0, 6'h20, 32'h0, r, stall);
        check("stall_cycles", 32'(stall), 32'd10);
        check("stall_acc0", r, 32'd172);

        // ---------------- taps == 0 is a no-op ----------------
        wr(6'h0C, 32'h4000);
        wr(6'h04, 32'h0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || !bif.bus_ready) n++;
        end
        check("taps0_busy", 32'(n), 32'h0);
        rd_check("taps0_acc0", 6'h20, 32'd172);

        // ---------------- reset in the middle of a run ----------------
        wr(6'h0C, 32'h4008);
        wr(6'h04, 32'h0);
        @(negedge clk);
        check("run_started", 32'(busy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_busy",  32'(busy), 32'h0);
        check("midrst_ready", 32'(bif.bus_ready), 32'h1);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_stays_idle", 32'(busy), 32'h0);
        rd_check("midrst_acc0", 6'h20, 32'h0);
        rd_check("midrst_acc1", 6'h24, 32'h0);
        rd_check("midrst_config", 6'h0C, 32'h0000_4008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
